// File: rtl/inference_sequencer.sv
// inference_sequencer: control FSM for one MNIST inference pass (image load, then each layer in turn).
// Optional macro SEQ_PERF_CNT_EN adds the cycle_count pass-latency counter; otherwise cycle_count is 0.
module inference_sequencer #(
    parameter int unsigned N_PIXELS       = 784,
    parameter int unsigned N_LAYERS       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_areset,
    input  logic                start,
    input  logic                abort,
    output logic                img_start,
    input  logic                x_tvalid,
    input  logic                x_tready,
    output logic [N_LAYERS-1:0] layer_start,
    input  logic [N_LAYERS-1:0] layer_done,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [CNT_W-1:0]    pixel_count,
    output logic [7:0]          layer_idx,
    output logic [31:0]         cycle_count
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAYER, S_DONE, S_ERROR} state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_LOAD_TO, ERR_LAYER_TO, ERR_OVERRUN} err_t;

    localparam logic [CNT_W-1:0] PIX_MAX  = CNT_W'(N_PIXELS);
    localparam logic [CNT_W-1:0] PIX_OVR  = CNT_W'(N_PIXELS + 1);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       LAST_IDX = 8'(N_LAYERS - 1);

    state_t              state_q, state_d;
    err_t                err_code_q, err_code_d;
    logic                start_q;
    logic                img_start_q, img_start_d;
    logic [N_LAYERS-1:0] layer_start_q, layer_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [CNT_W-1:0]    pixel_count_q, pixel_count_d;
    logic [CNT_W-1:0]    wd_q, wd_d;
    logic [7:0]          layer_idx_q, layer_idx_d;
    logic                l0_latch_q, l0_latch_d;

    logic beat;
    logic start_edge;
    logic idle_like;
    logic launch;
    logic layer_ev;

    assign beat       = x_tvalid & x_tready;
    assign start_edge = start & ~start_q;
    assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    assign launch     = start_edge & idle_like & ~abort;

    always_comb begin
        state_d       = state_q;
        err_code_d    = err_code_q;
        img_start_d   = 1'b0;
        layer_start_d = '0;
        done_d        = done_q;
        error_d       = error_q;
        pixel_count_d = pixel_count_q;
        wd_d          = wd_q;
        layer_idx_d   = layer_idx_q;
        l0_latch_d    = l0_latch_q;

        // A layer-0 done that arrived during LOAD counts as the done for index 0.
        layer_ev = 1'b0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (layer_idx_q == 8'(i)) layer_ev = layer_done[i];
        end
        if (layer_idx_q == 8'd0 && l0_latch_q) layer_ev = 1'b1;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_edge) begin
                        img_start_d      = 1'b1;
                        layer_start_d[0] = 1'b1;
                        pixel_count_d    = '0;
                        wd_d             = '0;
                        layer_idx_d      = '0;
                        l0_latch_d       = 1'b0;
                        done_d           = 1'b0;
                        error_d          = 1'b0;
                        err_code_d       = ERR_NONE;
                        state_d          = S_LOAD;
                    end else if (state_q == S_DONE && beat && pixel_count_q == PIX_MAX) begin
                        error_d       = 1'b1;
                        err_code_d    = ERR_OVERRUN;
                        pixel_count_d = PIX_OVR;
                        state_d       = S_ERROR;
                    end
                end
                S_LOAD: begin
                    wd_d = wd_q + CNT_W'(1);
                    if (layer_done[0]) l0_latch_d = 1'b1;
                    if (beat) pixel_count_d = pixel_count_q + CNT_W'(1);
                    if (beat && (pixel_count_q + CNT_W'(1)) == PIX_MAX) begin
                        state_d     = S_LAYER;
                        layer_idx_d = '0;
                        wd_d        = '0;
                    end else if ((wd_q + CNT_W'(1)) == TO_MAX) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_LOAD_TO;
                        state_d    = S_ERROR;
                    end
                end
                S_LAYER: begin
                    wd_d = wd_q + CNT_W'(1);
                    if (beat && pixel_count_q == PIX_MAX) begin
                        error_d       = 1'b1;
                        err_code_d    = ERR_OVERRUN;
                        pixel_count_d = PIX_OVR;
                        state_d       = S_ERROR;
                    end else if (layer_ev) begin
                        if (layer_idx_q == 8'd0) l0_latch_d = 1'b0;
                        if (layer_idx_q < LAST_IDX) begin
                            for (int unsigned i = 0; i < N_LAYERS; i++) begin
                                if (8'(i) == layer_idx_q + 8'd1) layer_start_d[i] = 1'b1;
                            end
                            layer_idx_d = layer_idx_q + 8'd1;
                            wd_d        = '0;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else if ((wd_q + CNT_W'(1)) == TO_MAX) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_LAYER_TO;
                        state_d    = S_ERROR;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_LAYER);
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q       <= S_IDLE;
            err_code_q    <= ERR_NONE;
            start_q       <= 1'b0;
            img_start_q   <= 1'b0;
            layer_start_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            pixel_count_q <= '0;
            wd_q          <= '0;
            layer_idx_q   <= '0;
            l0_latch_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_code_q    <= err_code_d;
            start_q       <= start;
            img_start_q   <= img_start_d;
            layer_start_q <= layer_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            pixel_count_q <= pixel_count_d;
            wd_q          <= wd_d;
            layer_idx_q   <= layer_idx_d;
            l0_latch_q    <= l0_latch_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (launch) cycle_count_d = '0;
        else if (busy_q) cycle_count_d = cycle_count_q + 32'd1;
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) cycle_count_q <= '0;
        else              cycle_count_q <= cycle_count_d;
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = '0;
`endif

    assign img_start   = img_start_q;
    assign layer_start = layer_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign pixel_count = pixel_count_q;
    assign layer_idx   = layer_idx_q;

endmodule
